// File: rtl/fifo_wr_arb_ctrl.sv
// Write-port arbiter and pointer/flag controller for an external fifo_mem array.
// Optional sticky underflow/overflow flags are enabled with `define FIFO_ERR_FLAGS_EN.
module fifo_wr_arb_ctrl #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_req0,
    input  logic [DATASIZE-1:0] i_data0,
    output logic                o_gnt0,
    input  logic                i_req1,
    input  logic [DATASIZE-1:0] i_data1,
    output logic                o_gnt1,
    input  logic                i_rd_en,
    output logic                o_wr_en,
    output logic [ADDRSIZE-1:0] o_wr_addr,
    output logic [DATASIZE-1:0] o_wr_data,
    output logic [ADDRSIZE-1:0] o_rd_addr,
    output logic                o_full,
    output logic                o_empty,
    output logic [ADDRSIZE:0]   o_count
`ifdef FIFO_ERR_FLAGS_EN
    ,
    input  logic                i_err_clr,
    output logic                o_udf_err,
    output logic                o_ovf_err
`endif
);

    logic [ADDRSIZE:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRSIZE:0] rd_ptr_q, rd_ptr_d;
    logic [ADDRSIZE:0] count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              last_gnt_q, last_gnt_d;
    logic              gnt0, gnt1;
    logic              push, pop;

    // Round-robin: on contention the producer that did not win last time is served.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!i_rst && !full_q) begin
            if (i_req0 && i_req1) begin
                gnt0 = last_gnt_q;
                gnt1 = ~last_gnt_q;
            end else if (i_req0) begin
                gnt0 = 1'b1;
            end else if (i_req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    always_comb begin
        push       = gnt0 | gnt1;
        pop        = i_rd_en & ~empty_q & ~i_rst;
        wr_ptr_d   = wr_ptr_q + {{ADDRSIZE{1'b0}}, push};
        rd_ptr_d   = rd_ptr_q + {{ADDRSIZE{1'b0}}, pop};
        last_gnt_d = push ? gnt1 : last_gnt_q;
        // Flags come from next-state pointers so they are valid right after the edge.
        empty_d    = (wr_ptr_d == rd_ptr_d);
        full_d     = (wr_ptr_d[ADDRSIZE] != rd_ptr_d[ADDRSIZE]) &&
                     (wr_ptr_d[ADDRSIZE-1:0] == rd_ptr_d[ADDRSIZE-1:0]);
        count_d    = wr_ptr_d - rd_ptr_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            last_gnt_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DATASIZE; gi++) begin : g_wdata
            assign o_wr_data[gi] = (gnt0 & i_data0[gi]) | (gnt1 & i_data1[gi]);
        end
    endgenerate

    assign o_gnt0    = gnt0;
    assign o_gnt1    = gnt1;
    assign o_wr_en   = push;
    assign o_wr_addr = wr_ptr_q[ADDRSIZE-1:0];
    assign o_rd_addr = rd_ptr_q[ADDRSIZE-1:0];
    assign o_full    = full_q;
    assign o_empty   = empty_q;
    assign o_count   = count_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic udf_q, udf_d;
    logic ovf_q, ovf_d;

    // A new error in the same cycle as a clear must survive the clear.
    always_comb begin
        udf_d = (i_rd_en & empty_q) | (udf_q & ~i_err_clr);
        ovf_d = ((i_req0 | i_req1) & full_q) | (ovf_q & ~i_err_clr);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            udf_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            udf_q <= udf_d;
            ovf_q <= ovf_d;
        end
    end

    assign o_udf_err = udf_q;
    assign o_ovf_err = ovf_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// Bench for fifo_wr_arb_ctrl: acts as fifo_mem and compares against a queue-based FIFO model.
// Error-flag checks are compiled in when FIFO_ERR_FLAGS_EN is defined.
module tb_fifo_wr_arb_ctrl;

    logic       clk;
    logic       rst;
    logic       req0, req1, rd_en;
    logic [7:0] data0, data1;
    logic       gnt0, gnt1, wr_en, full, empty;
    logic [3:0] wr_addr, rd_addr;
    logic [7:0] wr_data;
    logic [4:0] count;
    logic       err_clr;
`ifdef FIFO_ERR_FLAGS_EN
    logic       udf_err, ovf_err;
`endif

    fifo_wr_arb_ctrl #(.DATASIZE(8), .ADDRSIZE(4)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_req0   (req0),
        .i_data0  (data0),
        .o_gnt0   (gnt0),
        .i_req1   (req1),
        .i_data1  (data1),
        .o_gnt1   (gnt1),
        .i_rd_en  (rd_en),
        .o_wr_en  (wr_en),
        .o_wr_addr(wr_addr),
        .o_wr_data(wr_data),
        .o_rd_addr(rd_addr),
        .o_full   (full),
        .o_empty  (empty),
        .o_count  (count)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .i_err_clr(err_clr),
        .o_udf_err(udf_err),
        .o_ovf_err(ovf_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Storage array standing in for fifo_mem.
    logic [7:0] mem [16];
    always @(posedge clk) if (wr_en) mem[wr_addr] <= wr_data;

    // Reference model
    logic [7:0] q[$];
    logic       m_last;
    int         wr_cnt, rd_cnt;
    logic       m_udf, m_ovf;

    // Observed combinational outputs and model expectations for the latest cycle
    logic       o_g0, o_g1, o_wen;
    logic [7:0] o_wdata, o_head;
    logic       e_g0, e_g1, e_head_valid;
    logic [7:0] e_wdata, e_head;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic step(input logic r0, input logic r1, input logic [7:0] d0, input logic [7:0] d1,
                        input logic rd, input logic rs, input logic clr);
        logic mfull, mempty;
        req0 = r0; req1 = r1; data0 = d0; data1 = d1; rd_en = rd; rst = rs; err_clr = clr;
        #1;
        mfull  = (q.size() == 16);
        mempty = (q.size() == 0);
        e_g0 = 1'b0;
        e_g1 = 1'b0;
        if (!rs && !mfull) begin
            if (r0 && r1) begin
                if (m_last) e_g0 = 1'b1; else e_g1 = 1'b1;
            end else if (r0) e_g0 = 1'b1;
            else if (r1) e_g1 = 1'b1;
        end
        e_wdata      = e_g0 ? d0 : (e_g1 ? d1 : 8'h00);
        e_head_valid = !mempty;
        e_head       = mempty ? 8'h00 : q[0];
        o_g0 = gnt0; o_g1 = gnt1; o_wen = wr_en; o_wdata = wr_data; o_head = mem[rd_addr];
        @(posedge clk);
        if (rs) begin
            q.delete();
            wr_cnt = 0; rd_cnt = 0; m_last = 1'b1; m_udf = 1'b0; m_ovf = 1'b0;
        end else begin
            m_udf = (rd && mempty) ? 1'b1 : (clr ? 1'b0 : m_udf);
            m_ovf = ((r0 || r1) && mfull) ? 1'b1 : (clr ? 1'b0 : m_ovf);
            if (rd && !mempty) begin
                void'(q.pop_front());
                rd_cnt++;
            end
            if (e_g0 || e_g1) begin
                q.push_back(e_wdata);
                wr_cnt++;
                m_last = e_g1;
            end
        end
        $display("[TB] t=%0t rst=%0b req=%0b%0b gnt=%0b%0b wdata=%02h rd=%0b head=%02h model_cnt=%0d",
                 $time, rs, r1, r0, o_g1, o_g0, o_wdata, rd, o_head, q.size());
        @(negedge clk);
    endtask

    task automatic do_reset;
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        step(1'b1, 1'b1, 8'h55, 8'h66, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'h55, 8'h66, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if ({o_g0, o_g1} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b exp 00", {o_g0, o_g1}); end
        req0 = 0; req1 = 0; rd_en = 0; rst = 0; err_clr = 0;
        #1;
        n_tests++;
        if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", count); end
        n_tests++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b exp 1", empty); end
        n_tests++;
        if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b exp 0", full); end
        n_tests++;
        if ({gnt0, gnt1, wr_en} !== 3'b000) begin n_fail++; $display("FAIL reset_idle_gnt: got %b exp 000", {gnt0, gnt1, wr_en}); end
        n_tests++;
        if ({wr_addr, rd_addr} !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h exp 00", {wr_addr, rd_addr}); end
    endtask

    task automatic test_fill_drain;
        do_reset();
        for (int n = 0; n < 16; n++) begin
            step(1'b1, 1'b0, 8'(8'h10 + n), 8'h00, 1'b0, 1'b0, 1'b0);
            n_tests++;
            if ({o_g0, o_g1} !== 2'b10) begin n_fail++; $display("FAIL fill_gnt[%0d]: got %b exp 10", n, {o_g0, o_g1}); end
            n_tests++;
            if (count !== 5'(n + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d exp %0d", n, count, n + 1); end
        end
        n_tests++;
        if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b exp 1", full); end
        step(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if ({o_g0, o_g1, o_wen} !== 3'b000) begin n_fail++; $display("FAIL full_blocks_req: got %b exp 000", {o_g0, o_g1, o_wen}); end
        n_tests++;
        if (count !== 5'd16 || wr_addr !== 4'd0) begin n_fail++; $display("FAIL full_hold: got cnt=%0d wa=%0d exp 16/0", count, wr_addr); end
        for (int n = 0; n < 16; n++) begin
            step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
            n_tests++;
            if (o_head !== 8'(8'h10 + n)) begin n_fail++; $display("FAIL drain_data[%0d]: got %h exp %h", n, o_head, 8'(8'h10 + n)); end
            n_tests++;
            if (count !== 5'(15 - n)) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d exp %0d", n, count, 15 - n); end
        end
        n_tests++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b exp 1", empty); end
    endtask

    task automatic test_alternate;
        logic [7:0] exp_d;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 8'(8'hA0 + (i + 1) / 2), 8'(8'hB0 + i / 2), 1'b0, 1'b0, 1'b0);
            n_tests++;
            if ({o_g0, o_g1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL alt_gnt[%0d]: got %b exp %b", i, {o_g0, o_g1}, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
        end
        for (int k = 0; k < 8; k++) begin
            exp_d = (k % 2 == 0) ? 8'(8'hA0 + k / 2) : 8'(8'hB0 + k / 2);
            step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
            n_tests++;
            if (o_head !== exp_d) begin n_fail++; $display("FAIL alt_data[%0d]: got %h exp %h", k, o_head, exp_d); end
        end
    endtask

    task automatic test_full_pop_push;
        logic [7:0] exp_d;
        do_reset();
        for (int n = 0; n < 16; n++) step(1'b1, 1'b0, 8'(8'hC0 + n), 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00, 8'hEE, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if ({o_g0, o_g1} !== 2'b00) begin n_fail++; $display("FAIL fullpop_blocked: got %b exp 00", {o_g0, o_g1}); end
        n_tests++;
        if (o_head !== 8'hC0) begin n_fail++; $display("FAIL fullpop_data: got %h exp c0", o_head); end
        n_tests++;
        if (count !== 5'd15 || full !== 1'b0) begin n_fail++; $display("FAIL fullpop_count: got %0d/%b exp 15/0", count, full); end
        step(1'b0, 1'b1, 8'h00, 8'hEE, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if ({o_g0, o_g1} !== 2'b01) begin n_fail++; $display("FAIL fullpop_regrant: got %b exp 01", {o_g0, o_g1}); end
        n_tests++;
        if (count !== 5'd16 || full !== 1'b1) begin n_fail++; $display("FAIL fullpop_refill: got %0d/%b exp 16/1", count, full); end
        for (int k = 0; k < 16; k++) begin
            exp_d = (k < 15) ? 8'(8'hC1 + k) : 8'hEE;
            step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
            n_tests++;
            if (o_head !== exp_d) begin n_fail++; $display("FAIL fullpop_drain[%0d]: got %h exp %h", k, o_head, exp_d); end
        end
    endtask

    task automatic test_stream;
        int         wraps_w, wraps_r;
        logic [3:0] prev_w, prev_r;
        do_reset();
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        wraps_w = 0; wraps_r = 0; prev_w = wr_addr; prev_r = rd_addr;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, 8'(i + 1), 8'h00, 1'b1, 1'b0, 1'b0);
            n_tests++;
            if (o_head !== 8'(i)) begin n_fail++; $display("FAIL stream_data[%0d]: got %h exp %h", i, o_head, 8'(i)); end
            n_tests++;
            if (count !== 5'd1) begin n_fail++; $display("FAIL stream_count[%0d]: got %0d exp 1", i, count); end
            if (prev_w == 4'd15 && wr_addr == 4'd0) wraps_w++;
            if (prev_r == 4'd15 && rd_addr == 4'd0) wraps_r++;
            prev_w = wr_addr; prev_r = rd_addr;
        end
        n_tests++;
        if (wraps_w != 2 || wraps_r != 2) begin n_fail++; $display("FAIL stream_wraps: got w=%0d r=%0d exp 2/2", wraps_w, wraps_r); end
    endtask

    task automatic test_random;
        logic r0, r1, rd, rs;
        int   push_pct;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            push_pct = ((i / 50) % 2 == 0) ? 80 : 25;
            r0 = ($urandom_range(0, 99) < push_pct);
            r1 = ($urandom_range(0, 99) < push_pct);
            rd = ($urandom_range(0, 99) < 100 - push_pct);
            rs = ($urandom_range(0, 99) < 2);
            step(r0, r1, 8'($urandom), 8'($urandom), rd, rs, 1'($urandom_range(0, 1)));
            n_tests++;
            if ({o_g0, o_g1, o_wen} !== {e_g0, e_g1, e_g0 | e_g1}) begin
                n_fail++; $display("FAIL rnd_gnt[%0d]: got %b exp %b", i, {o_g0, o_g1, o_wen}, {e_g0, e_g1, e_g0 | e_g1});
            end
            n_tests++;
            if (o_wdata !== e_wdata) begin n_fail++; $display("FAIL rnd_wdata[%0d]: got %h exp %h", i, o_wdata, e_wdata); end
            if (e_head_valid) begin
                n_tests++;
                if (o_head !== e_head) begin n_fail++; $display("FAIL rnd_head[%0d]: got %h exp %h", i, o_head, e_head); end
            end
            n_tests++;
            if ({count, empty, full} !== {5'(q.size()), q.size() == 0, q.size() == 16}) begin
                n_fail++; $display("FAIL rnd_flags[%0d]: got cnt=%0d e=%b f=%b exp cnt=%0d", i, count, empty, full, q.size());
            end
            n_tests++;
            if ({wr_addr, rd_addr} !== {4'(wr_cnt % 16), 4'(rd_cnt % 16)}) begin
                n_fail++; $display("FAIL rnd_addr[%0d]: got %0d/%0d exp %0d/%0d", i, wr_addr, rd_addr, wr_cnt % 16, rd_cnt % 16);
            end
`ifdef FIFO_ERR_FLAGS_EN
            n_tests++;
            if ({udf_err, ovf_err} !== {m_udf, m_ovf}) begin
                n_fail++; $display("FAIL rnd_err[%0d]: got %b exp %b", i, {udf_err, ovf_err}, {m_udf, m_ovf});
            end
`endif
        end
        err_clr = 1'b0;
    endtask

`ifdef FIFO_ERR_FLAGS_EN
    task automatic test_err_flags;
        do_reset();
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (udf_err !== 1'b1) begin n_fail++; $display("FAIL udf_set: got %b exp 1", udf_err); end
        n_tests++;
        if ({wr_addr, rd_addr, count} !== 13'd0) begin n_fail++; $display("FAIL udf_state: got %h exp 0", {wr_addr, rd_addr, count}); end
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (udf_err !== 1'b0) begin n_fail++; $display("FAIL udf_clr: got %b exp 0", udf_err); end
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
        n_tests++;
        if (udf_err !== 1'b1) begin n_fail++; $display("FAIL udf_set_wins: got %b exp 1", udf_err); end
        for (int n = 0; n < 16; n++) step(1'b1, 1'b0, 8'(n), 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 8'h00, 8'h33, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if ({udf_err, ovf_err} !== 2'b01) begin n_fail++; $display("FAIL ovf_set: got %b exp 01", {udf_err, ovf_err}); end
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b exp 0", ovf_err); end
        err_clr = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_burst;
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'(8'h40 + i), 8'(8'h50 + i), i > 2, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h77, 8'h88, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if ({o_g0, o_g1} !== 2'b00) begin n_fail++; $display("FAIL midrst_gnt: got %b exp 00", {o_g0, o_g1}); end
        n_tests++;
        if ({count, empty, full, wr_addr, rd_addr} !== {5'd0, 1'b1, 1'b0, 8'h00}) begin
            n_fail++; $display("FAIL midrst_state: got cnt=%0d e=%b f=%b wa=%0d ra=%0d exp 0/1/0/0/0", count, empty, full, wr_addr, rd_addr);
        end
        step(1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if ({o_g0, o_g1} !== 2'b10) begin n_fail++; $display("FAIL midrst_first_winner: got %b exp 10", {o_g0, o_g1}); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req0 = 0; req1 = 0; rd_en = 0; err_clr = 0; data0 = 0; data1 = 0;
        q.delete(); m_last = 1'b1; wr_cnt = 0; rd_cnt = 0; m_udf = 0; m_ovf = 0;
        @(negedge clk);
        test_reset();
        test_fill_drain();
        test_alternate();
        test_full_pop_push();
        test_stream();
`ifdef FIFO_ERR_FLAGS_EN
        test_err_flags();
`endif
        test_reset_mid_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
